// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory responder.
// Holds the grant FSM states, parameter defaults and the out-of-range read pattern.
package data_mem_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam int MEM_WORDS_DEF = 1024;
    localparam int GNT_STALL_DEF = 0;
    localparam int RESP_LAT_DEF  = 1;

    localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;

    // Response payload: reads return the word (or the OOR pattern), writes return zero.
    function automatic logic [31:0] resp_data(input logic        we,
                                              input logic        in_range,
                                              input logic [31:0] word);
        logic [31:0] r;
        r = '0;
        if (!we) begin
            r = in_range ? word : OOR_RDATA;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// LSU data bus: request/handshake from the core side, response from the memory side.
// Signal names follow the core's port naming (suffix is from the core's point of view).
interface data_mem_if;

    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o,
        output data_we_o,
        output data_be_o,
        output data_addr_o,
        output data_wdata_o,
        input  data_gnt_i,
        input  data_rvalid_i,
        input  data_rdata_i
    );

    modport slave (
        input  data_req_o,
        input  data_we_o,
        input  data_be_o,
        input  data_addr_o,
        input  data_wdata_o,
        output data_gnt_i,
        output data_rvalid_i,
        output data_rdata_i
    );

endinterface

// File: rtl/data_mem_resp_pipe.sv
// Fixed-latency response delay line of {valid, data}; data is forced to zero on
// empty slots so the output word is already zero whenever valid is low.
module data_mem_resp_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_vld,
    input  logic [W-1:0] i_data,
    output logic         o_vld,
    output logic [W-1:0] o_data
);

    logic [DEPTH-1:0]        r_vld_pipe;
    logic [DEPTH-1:0][W-1:0] r_data_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe  <= '0;
            r_data_pipe <= '0;
        end else begin
            r_vld_pipe[0]  <= i_vld;
            r_data_pipe[0] <= i_vld ? i_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_data_pipe[i] <= r_data_pipe[i-1];
            end
        end
    end

    assign o_vld  = r_vld_pipe[DEPTH-1];
    assign o_data = r_data_pipe[DEPTH-1];

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind an LSU req/gnt/rvalid bus, with a
// configurable grant stall and fixed response latency.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int GNT_STALL = GNT_STALL_DEF,
    parameter int RESP_LAT  = RESP_LAT_DEF
) (
    input  logic  clk,
    input  logic  rst,
    data_mem_if.slave bus
);

    localparam int AW = $clog2(MEM_WORDS);

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_mem [MEM_WORDS];

    logic          w_gnt;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rsp_data;

    assign w_in_range = (bus.data_addr_o[31:AW+2] == '0);
    assign w_idx      = bus.data_addr_o[AW+1:2];

    // Grant is combinational so a zero-stall memory accepts in the request cycle.
    always_comb begin
        w_gnt = 1'b0;
        if (!rst && bus.data_req_o) begin
            if (GNT_STALL == 0) begin
                w_gnt = 1'b1;
            end else begin
                w_gnt = (r_state == STALL) && (r_cnt == '0);
            end
        end
    end

    assign bus.data_gnt_i = w_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (GNT_STALL != 0 && bus.data_req_o) begin
                        r_state <= STALL;
                        r_cnt   <= 4'(GNT_STALL - 1);
                    end
                end
                STALL: begin
                    // A dropped request abandons the wait; a grant returns to IDLE so
                    // the next request pays the full stall again.
                    if (!bus.data_req_o || r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt && bus.data_we_o && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_be_o[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.data_wdata_o[8*b +: 8];
                end
            end
        end
    end

    assign w_rsp_data = resp_data(bus.data_we_o, w_in_range, r_mem[w_idx]);

    data_mem_resp_pipe #(
        .DEPTH (RESP_LAT),
        .W     (32)
    ) u_resp_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_gnt),
        .i_data (w_rsp_data),
        .o_vld  (bus.data_rvalid_i),
        .o_data (bus.data_rdata_i)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responder instances cover zero-stall, stalled-grant and
// multi-cycle-latency configurations against hand-computed cycle tables.
module tb_data_mem_responder;
    import data_mem_pkg::*;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    localparam int NA = 12;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    data_mem_if ia ();
    data_mem_if ib ();
    data_mem_if ic ();

    data_mem_responder #(.MEM_WORDS(1024), .GNT_STALL(0), .RESP_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave));
    data_mem_responder #(.MEM_WORDS(1024), .GNT_STALL(3), .RESP_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave));
    data_mem_responder #(.MEM_WORDS(1024), .GNT_STALL(0), .RESP_LAT(4)) dut_c (
        .clk(clk), .rst(rst), .bus(ic.slave));

    always #5 clk = ~clk;

    vec_t va [NA] = '{
        '{1'b1, 4'hF, 32'h0000_0010, 32'hA5A5_1234, 32'h0000_0000},
        '{1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000, 32'hA5A5_1234},
        '{1'b1, 4'hF, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0000},
        '{1'b1, 4'h5, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000},
        '{1'b0, 4'hF, 32'h0000_0020, 32'h0000_0000, 32'hFF00_FF00},
        '{1'b1, 4'h0, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000},
        '{1'b0, 4'h0, 32'h0000_0020, 32'h0000_0000, 32'hFF00_FF00},
        '{1'b1, 4'hF, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000},
        '{1'b1, 4'hF, 32'h0000_1000, 32'h2222_2222, 32'h0000_0000},
        '{1'b0, 4'hF, 32'h0000_1000, 32'h0000_0000, 32'hDEAD_BEEF},
        '{1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'h1111_1111},
        '{1'b0, 4'hF, 32'h0000_0013, 32'h0000_0000, 32'hA5A5_1234}
    };

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ia.data_req_o = 1'b0; ia.data_we_o = 1'b0; ia.data_be_o = 4'h0;
        ia.data_addr_o = '0;  ia.data_wdata_o = '0;
        ib.data_req_o = 1'b1; ib.data_we_o = 1'b0; ib.data_be_o = 4'hF;
        ib.data_addr_o = 32'h0000_1000; ib.data_wdata_o = '0;
        ic.data_req_o = 1'b1; ic.data_we_o = 1'b0; ic.data_be_o = 4'hF;
        ic.data_addr_o = '0;  ic.data_wdata_o = '0;

        // Reset state, with requests held to show grant is masked.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt_b",    32'(ib.data_gnt_i),    32'd0);
        chk("rst_gnt_c",    32'(ic.data_gnt_i),    32'd0);
        chk("rst_rvalid_a", 32'(ia.data_rvalid_i), 32'd0);
        chk("rst_rdata_a",  ia.data_rdata_i,       32'd0);
        chk("rst_rvalid_c", 32'(ic.data_rvalid_i), 32'd0);
        chk("rst_rdata_c",  ic.data_rdata_i,       32'd0);
        ic.data_req_o = 1'b0;

        // Stalled grants: req high from cycle 0, grants at 3,7,11,15; OOR reads.
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            if (c == 16) ib.data_req_o = 1'b0;
            #1;
            chk($sformatf("stall_gnt_c%0d", c), 32'(ib.data_gnt_i),
                32'(c == 3 || c == 7 || c == 11 || c == 15));
            chk($sformatf("stall_rvalid_c%0d", c), 32'(ib.data_rvalid_i),
                32'(c == 4 || c == 8 || c == 12 || c == 16));
            chk($sformatf("stall_rdata_c%0d", c), ib.data_rdata_i,
                (c == 4 || c == 8 || c == 12 || c == 16) ? 32'hDEAD_BEEF : 32'h0);
            @(negedge clk);
        end

        // Request dropped mid-stall: the retry must wait the full stall again.
        for (int c = 0; c <= 6; c++) begin
            ib.data_req_o = (c != 1 && c != 6);
            #1;
            chk($sformatf("abort_gnt_c%0d", c), 32'(ib.data_gnt_i), 32'(c == 5));
            @(negedge clk);
        end

        // Zero-stall, latency-1 back-to-back table: writes, partial writes, OOR.
        for (int i = 0; i <= NA; i++) begin
            if (i > 0) begin
                chk($sformatf("a_rvalid_%0d", i-1), 32'(ia.data_rvalid_i), 32'd1);
                chk($sformatf("a_rdata_%0d", i-1),  ia.data_rdata_i, va[i-1].rdata);
            end
            if (i < NA) begin
                ia.data_req_o   = 1'b1;
                ia.data_we_o    = va[i].we;
                ia.data_be_o    = va[i].be;
                ia.data_addr_o  = va[i].addr;
                ia.data_wdata_o = va[i].wdata;
                #1;
                chk($sformatf("a_gnt_%0d", i), 32'(ia.data_gnt_i), 32'd1);
            end else begin
                ia.data_req_o = 1'b0;
                #1;
                chk("a_gnt_idle", 32'(ia.data_gnt_i), 32'd0);
            end
            @(negedge clk);
        end
        chk("a_rvalid_end", 32'(ia.data_rvalid_i), 32'd0);
        chk("a_rdata_end",  ia.data_rdata_i,       32'd0);

        // Latency-4: preload words 0..3, then read them back-to-back.
        for (int i = 0; i < 4; i++) begin
            ic.data_req_o = 1'b1; ic.data_we_o = 1'b1; ic.data_be_o = 4'hF;
            ic.data_addr_o = 32'(i * 4); ic.data_wdata_o = 32'(i);
            @(negedge clk);
        end
        ic.data_req_o = 1'b0;
        ic.data_we_o  = 1'b0;
        repeat (6) @(negedge clk);
        for (int c = 0; c <= 9; c++) begin
            ic.data_req_o  = (c < 4);
            ic.data_addr_o = (c < 4) ? 32'(c * 4) : 32'h0;
            #1;
            if (c < 4) chk($sformatf("lat_gnt_c%0d", c), 32'(ic.data_gnt_i), 32'd1);
            chk($sformatf("lat_rvalid_c%0d", c), 32'(ic.data_rvalid_i), 32'(c >= 4 && c <= 7));
            chk($sformatf("lat_rdata_c%0d", c), ic.data_rdata_i,
                (c >= 4 && c <= 7) ? 32'(c - 4) : 32'h0);
            @(negedge clk);
        end

        // Reset two cycles after a grant flushes it; the post-reset request completes.
        for (int c = 0; c <= 10; c++) begin
            rst            = (c == 2);
            ic.data_req_o  = (c == 0 || c == 2 || c == 3);
            ic.data_addr_o = (c == 0) ? 32'h4 : 32'h8;
            #1;
            chk($sformatf("rst_gnt_c%0d", c), 32'(ic.data_gnt_i), 32'(c == 0 || c == 3));
            chk($sformatf("rst_rvalid_c%0d", c), 32'(ic.data_rvalid_i), 32'(c == 7));
            chk($sformatf("rst_rdata_c%0d", c), ic.data_rdata_i, (c == 7) ? 32'h2 : 32'h0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning memory depth in 32-bit words (power of 2, >=2).
REQ-002 SHALL have parameter GNT_STALL, default 0, meaning wait cycles between first req cycle and gnt (0..15).
REQ-003 SHALL have parameter RESP_LAT, default 1, meaning cycles from gnt cycle to rvalid (1..8).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port data_req_o, input, 1, LSU request valid.
REQ-007 SHALL have port data_we_o, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port data_be_o, input, 4, byte enables; bit i qualifies wdata[8i+7:8i].
REQ-009 SHALL have port data_addr_o, input, 32, byte address; bits [1:0] ignored.
REQ-010 SHALL have port data_wdata_o, input, 32, write data.
REQ-011 SHALL have port data_gnt_i, output, 1, request accepted this cycle.
REQ-012 SHALL have port data_rvalid_i, output, 1, response valid.
REQ-013 SHALL have port data_rdata_i, output, 32, read data, qualified by rvalid.

Function
REQ-014 SHALL accept a transaction only in a cycle with data_req_o=1 and data_gnt_i=1 (handshake).
REQ-015 SHALL drive data_gnt_i combinationally from data_req_o and FSM state; gnt=0 whenever req=0.
REQ-016 FSM SHALL have states IDLE and STALL; with GNT_STALL=0 it SHALL stay in IDLE and gnt=req.
REQ-017 With GNT_STALL>0, IDLE with req=1 SHALL give gnt=0, load stall counter with GNT_STALL-1, and enter STALL.
REQ-018 In STALL, counter SHALL decrement each cycle; when counter==0 and req=1, gnt=1 and next state IDLE.
REQ-019 If req drops to 0 in STALL (protocol violation), the FSM SHALL return to IDLE without granting.
REQ-020 Back-to-back requests SHALL each incur the full GNT_STALL wait; the first stall cycle follows the grant cycle.
REQ-021 Word index SHALL be data_addr_o[log2(MEM_WORDS)+1:2]; the address is in range iff data_addr_o[31:log2(MEM_WORDS)+2]==0.
REQ-022 An accepted in-range write SHALL update, at the grant edge, only the bytes whose data_be_o bit is 1.
REQ-023 An accepted write with be=4'b0000 or an out-of-range address SHALL leave memory unchanged.
REQ-024 An accepted read SHALL sample the memory word at the grant edge, including writes granted in earlier cycles; be does not mask read data.
REQ-025 An out-of-range read SHALL return 32'hDEAD_BEEF; every write response SHALL return rdata=0.
REQ-026 Each accepted transaction SHALL produce exactly one rvalid pulse RESP_LAT cycles after its grant cycle, in grant order.
REQ-027 Up to RESP_LAT responses SHALL be in flight; grants SHALL never be withheld for response back-pressure.
REQ-028 When data_rvalid_i=0, data_rdata_i SHALL be 0.

Reset
REQ-029 While rst=1 at a clock edge: FSM to IDLE, stall counter to 0, all response pipeline valid bits to 0, and data_rdata_i to 0.
REQ-030 Reset mid-operation SHALL discard all in-flight responses; none SHALL appear after reset deasserts.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 data_gnt_i SHALL be 0 during any cycle with rst=1.

Structure
REQ-033 Package data_mem_pkg SHALL hold the FSM state enum (IDLE, STALL), the parameter defaults, and the constant OOR_RDATA = 32'hDEAD_BEEF.
REQ-034 Response delay SHALL be a sub-module data_mem_resp_pipe: a RESP_LAT-deep shift register of {valid, data}, synchronously cleared by rst.
REQ-035 Memory SHALL be an inferred array of MEM_WORDS x 32 bits with per-byte write enables.

Verification
REQ-036 GNT_STALL=0, RESP_LAT=1: write addr 0x10, be=1111, wdata 0xA5A5_1234, then read 0x10 -> gnt same cycle as each req; read rvalid 1 cycle after its gnt with rdata 0xA5A5_1234.
REQ-037 Partial write: write 0x20 with 0xFFFF_FFFF, be=1111, then 0x0000_0000 with be=0101, then read 0x20 -> rdata 0xFF00_FF00.
REQ-038 GNT_STALL=3: req held high from cycle 0 -> gnt in cycle 3; 4 back-to-back reads -> gnts in cycles 3, 7, 11, 15.
REQ-039 RESP_LAT=4, GNT_STALL=0, 4 consecutive reads of words 0..3 preloaded with 0x0..0x3 -> rvalid in cycles 4..7 carrying 0x0, 0x1, 0x2, 0x3 in order.
REQ-040 Out of range with MEM_WORDS=1024: read addr 0x0000_1000 -> rdata 0xDEAD_BEEF; write the same address, then read word 0 -> word 0 unchanged.
REQ-041 RESP_LAT=4: assert rst for 1 cycle 2 cycles after a grant -> no rvalid ever follows; the next request after reset completes normally.
